// File: rtl/vram_write_queue.sv
// CPU write queue into the plane-interleaved VRAM: edge-detects writes to 8000h-FFFFh,
// buffers them in a FIFO and issues one byte write per granted cycle.
// Optional build macro VRAM_WR_STATS_EN adds saturating write/drop counters.
module vram_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic [15:0]   cpu_addr,
    input  logic [7:0]    cpu_din,
    input  logic          cpu_we,
    input  logic          flush,
    input  logic          vram_gnt,
    output logic [14:0]   vram_wraddr,
    output logic [7:0]    vram_data,
    output logic          vram_wren,
    output logic [AW:0]   fifo_level,
    output logic          overflow,
    input  logic          ovf_clr,
    output logic          wr_state
`ifdef VRAM_WR_STATS_EN
    ,
    output logic [15:0]   wr_count,
    output logic [15:0]   drop_count
`endif
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } out_state_t;

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    out_state_t        state;
    logic              we_d;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [22:0]       mem [DEPTH];

    logic              push_req;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              push_ok;
    logic              drop;
    logic [14:0]       scr_addr;

    // Handshake: an entry is offered whenever the FIFO is non-empty (valid); vram_gnt
    // is the ready. A pop happens only when both are high and no flush is in progress.
    assign push_req   = cpu_we & ~we_d & cpu_addr[15];
    assign fifo_full  = (fifo_level == FULL_LVL);
    assign fifo_empty = (fifo_level == '0);
    assign pop        = ~fifo_empty & vram_gnt & ~flush;
    assign push_ok    = push_req & ~flush & (~fifo_full | pop);
    assign drop       = push_req & ~flush & fifo_full & ~pop;
    assign scr_addr   = {cpu_addr[12:0], cpu_addr[14:13]};
    assign wr_state   = (state == ST_WRITE);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            we_d       <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            we_d <= cpu_we;
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_level <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
                fifo_level <= fifo_level + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
            end
            // A drop in the same cycle as ovf_clr keeps the flag set.
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    // Storage carries no reset; occupancy is tracked solely by the pointers and level.
    always_ff @(posedge clk_sys) begin
        if (push_ok)
            mem[wr_ptr] <= {scr_addr, cpu_din};
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            vram_wren   <= 1'b0;
            vram_wraddr <= '0;
            vram_data   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state       <= ST_WRITE;
                        vram_wren   <= 1'b1;
                        vram_wraddr <= mem[rd_ptr][22:8];
                        vram_data   <= mem[rd_ptr][7:0];
                    end else begin
                        vram_wren <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (pop) begin
                        vram_wren   <= 1'b1;
                        vram_wraddr <= mem[rd_ptr][22:8];
                        vram_data   <= mem[rd_ptr][7:0];
                    end else begin
                        state     <= ST_IDLE;
                        vram_wren <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    vram_wren <= 1'b0;
                end
            endcase
        end
    end

`ifdef VRAM_WR_STATS_EN
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_count   <= '0;
            drop_count <= '0;
        end else if (ovf_clr) begin
            wr_count   <= '0;
            drop_count <= '0;
        end else begin
            if (vram_wren && wr_count != 16'hFFFF)
                wr_count <= wr_count + 16'd1;
            if (drop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule
